// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock LSB first,
// through a single full-subtractor cell and a borrow flip-flop.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_bin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_bout
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_d;
    logic             r_br;
    logic [CW-1:0]    r_cnt;

    logic             w_d;
    logic             w_bo;
    logic             w_last;

    // Full-subtractor cell on the current LSBs and the stored borrow
    assign w_d    = r_a[0] ^ r_b[0] ^ r_br;
    assign w_bo   = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    assign w_last = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_d     <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            o_diff  <= '0;
            o_bout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        r_a     <= i_a;
                        r_b     <= i_b;
                        r_br    <= i_bin;
                        r_cnt   <= '0;
                        o_busy  <= 1'b1;
                        r_state <= S_SHIFT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    r_br <= w_bo;
                    r_a  <= r_a >> 1;
                    r_b  <= r_b >> 1;
                    r_d  <= {w_d, r_d[WIDTH-1:1]};
                    if (w_last) begin
                        o_diff  <= {w_d, r_d[WIDTH-1:1]};
                        o_bout  <= w_bo;
                        o_busy  <= 1'b0;
                        o_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    o_busy  <= 1'b0;
                    o_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor computing `diff = a - b - bin` one bit per clock, LSB first, through a single 1-bit full-subtractor cell and a borrow flip-flop. It is the inverse-operation companion to the combinational 1-bit full adder: same cell-level arithmetic, run in the other direction and sequenced in time. It sits behind a start/done handshake so arithmetic datapaths can trade area for latency.

## Interface
- `WIDTH`, 8, operand and result width in bits (≥2)
- `clk` input 1, rising-edge clock
- `rst` input 1, asynchronous active-high reset
- `start` input 1, request: sample operands this cycle
- `a` input WIDTH, minuend, sampled only when start is accepted
- `b` input WIDTH, subtrahend, sampled only when start is accepted
- `bin` input 1, borrow-in, sampled only when start is accepted
- `busy` output 1, high while a subtraction is in progress
- `done` output 1, one-cycle pulse: result valid
- `diff` output WIDTH, result `(a - b - bin) mod 2^WIDTH`, registered
- `bout` output 1, final borrow: 1 iff `a < b + bin` (unsigned)

## Operation
- One clock; reset is asynchronous and active-high.
- States: IDLE, SHIFT, DONE.
- IDLE: busy=0, done=0. If start=1 at a rising edge: load shift registers `ra<=a`, `rb<=b`, borrow `br<=bin`, bit counter `cnt<=0`, go to SHIFT.
- SHIFT: busy=1. Each edge: `d = ra[0]^rb[0]^br`; `br <= (~ra[0]&rb[0]) | (~(ra[0]^rb[0])&br)`; shift ra, rb right by one; shift d into MSB of result shift register `rd`; `cnt <= cnt+1`. On the edge where `cnt == WIDTH-1`: copy completed `{d, rd[WIDTH-1:1]}` into `diff`, new borrow into `bout`, go to DONE.
- DONE: done=1, busy=0 for exactly one cycle. start=1 in DONE is accepted (back-to-back, same as IDLE, goes to SHIFT); otherwise go to IDLE.
- start while in SHIFT: ignored, no effect on operands or counter.
- `diff`/`bout` change only on completion; hold last result through IDLE and through the next SHIFT.
- Counter width `$clog2(WIDTH)`; no wrap beyond WIDTH-1.
- Reset mid-operation: immediately abort, return to IDLE, all outputs cleared; no done pulse for the aborted operation.

## Timing
- Reset values: busy=0, done=0, diff=0, bout=0, state IDLE.
- start accepted at edge E0 → busy high from E0 through edge E0+WIDTH; done high in the cycle following edge E0+WIDTH; diff/bout valid from that same edge.
- Latency start-to-done: WIDTH+1 cycles; throughput with back-to-back start: one result per WIDTH+1 cycles.
- Operands may change any time after the accepting edge.
- done and busy never high simultaneously.

## Test plan
- WIDTH=8, a=200, b=55, bin=0 → after 9 cycles done=1, diff=145, bout=0; done low the next cycle.
- WIDTH=8, a=5, b=10, bin=0 → diff=251 (8'hFB), bout=1; a=0, b=0, bin=1 → diff=255, bout=1.
- Exhaustive WIDTH=3: all a,b∈0..7, bin∈0..1 (128 cases) → diff=(a-b-bin) mod 8, bout=(a<b+bin); print PASS per case, FATAL with expected/actual on mismatch.
- start pulsed again 3 cycles into an operation with different a,b → ignored; result matches first operands, done at the original cycle.
- Assert rst 4 cycles into a WIDTH=8 operation → busy, done, diff, bout all 0 immediately; no done pulse; a new start after reset release completes correctly.
- start held high continuously with operands changed each DONE cycle → consecutive done pulses exactly 9 cycles apart, each result matching the operands present at its accepting edge.
